// File: rtl/peripheral_uart_tx_ctrl_wb_if.sv
// TX FIFO read-side connection between the UART transmit sequencer and the TX FIFO.
// The sequencer (master) issues pop strobes; the FIFO (slave) presents occupancy
// and its head entry combinationally.
interface peripheral_uart_tx_ctrl_wb_if #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
);
    logic [FIFO_COUNTER_W-1:0] tf_count;
    logic [FIFO_WIDTH-1:0]     tf_data_out;
    logic                      tf_pop;

    modport master (
        input  tf_count,
        input  tf_data_out,
        output tf_pop
    );

    modport slave (
        output tf_count,
        output tf_data_out,
        input  tf_pop
    );
endinterface

// File: rtl/peripheral_uart_tx_ctrl_wb.sv
// UART transmit sequencer. Pops one byte at a time from the TX FIFO and
// serialises it as start / data (LSB first) / optional parity / stop, each bit
// lasting 16 ticks of the 16x baud enable. Reports FSM state and THRE/TEMT.
module peripheral_uart_tx_ctrl_wb #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                                clk,
    input  logic                                wb_rst_i,
    input  logic                                enable,
    input  logic [7:0]                          lcr,
    peripheral_uart_tx_ctrl_wb_if.master        fifo,
    output logic                                stx_pad_o,
    output logic [2:0]                          tstate,
    output logic                                tx_busy,
    output logic                                thre,
    output logic                                temt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_t;

    localparam logic [FIFO_COUNTER_W-1:0] FIFO_EMPTY = '0;

    tx_state_t               state_reg, state_next;
    logic [3:0]              tick_reg, tick_next;
    logic [2:0]              bit_reg, bit_next;
    logic [FIFO_WIDTH-1:0]   shift_reg, shift_next;
    logic [5:0]              cfg_reg, cfg_next;
    logic                    par_reg, par_next;
    logic                    half_reg, half_next;   // first 16 ticks of a long stop done
    logic                    line_reg, line_next;   // FSM line level before break gating
    logic                    pad_reg;

    logic                    bit_end;
    logic                    bit_last;
    logic [3:0]              tick_inc;
    logic [FIFO_WIDTH-1:0]   word_mask;
    logic                    data_xor;
    logic                    par_calc;

    // A bit period closes on the 16th counted enable.
    assign bit_end  = enable && (tick_reg == 4'hF);
    assign tick_inc = tick_reg + 4'd1;
    assign bit_last = (bit_reg == (3'd4 + {1'b0, cfg_reg[1:0]}));

    // Valid-bit mask for the latched word length (5..8 bits).
    generate
        for (genvar gi = 0; gi < FIFO_WIDTH; gi++) begin : g_word_mask
            localparam int BIT_IDX = gi;
            assign word_mask[gi] = (BIT_IDX < (5 + int'(cfg_reg[1:0])));
        end
    endgenerate

    // Parity is evaluated while the start bit is on the line, when the shift
    // register still holds the whole latched byte.
    assign data_xor = ^(shift_reg & word_mask);
    assign par_calc = cfg_reg[5] ? ~cfg_reg[4] : (cfg_reg[4] ? data_xor : ~data_xor);

    // Next-state and datapath decode; everything holds unless a case updates it.
    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        cfg_next   = cfg_reg;
        par_next   = par_reg;
        half_next  = half_reg;
        line_next  = line_reg;
        case (state_reg)
            ST_IDLE: begin
                line_next = 1'b1;
                if (fifo.tf_count != FIFO_EMPTY) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                shift_next = fifo.tf_data_out;
                cfg_next   = lcr[5:0];
                tick_next  = 4'd0;
                bit_next   = 3'd0;
                half_next  = 1'b0;
                line_next  = 1'b0;
                state_next = ST_START;
            end
            ST_START: begin
                if (enable) begin
                    tick_next = tick_inc;
                end
                if (bit_end) begin
                    par_next   = par_calc;
                    line_next  = shift_reg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (enable) begin
                    tick_next = tick_inc;
                end
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    bit_next   = bit_reg + 3'd1;
                    if (bit_last) begin
                        if (cfg_reg[3]) begin
                            line_next  = par_reg;
                            state_next = ST_PARITY;
                        end else begin
                            line_next  = 1'b1;
                            state_next = ST_STOP;
                        end
                    end else begin
                        line_next = shift_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (enable) begin
                    tick_next = tick_inc;
                end
                if (bit_end) begin
                    line_next  = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (enable) begin
                    tick_next = tick_inc;
                end
                if (bit_end) begin
                    if (cfg_reg[2] && !half_reg) begin
                        // Second stop segment: 8 more ticks for 5-bit words, 16 otherwise.
                        half_next = 1'b1;
                        tick_next = (cfg_reg[1:0] == 2'b00) ? 4'd8 : 4'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                line_next  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            tick_reg  <= 4'd0;
            bit_reg   <= 3'd0;
            shift_reg <= '0;
            cfg_reg   <= 6'd0;
            par_reg   <= 1'b0;
            half_reg  <= 1'b0;
            line_reg  <= 1'b1;
            pad_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            cfg_reg   <= cfg_next;
            par_reg   <= par_next;
            half_reg  <= half_next;
            line_reg  <= line_next;
            // Break is applied on the live lcr at the output register only.
            pad_reg   <= line_next & ~lcr[6];
        end
    end

    assign fifo.tf_pop = (state_reg == ST_POP);
    assign stx_pad_o   = pad_reg;
    assign tstate      = state_reg;
    assign tx_busy     = (state_reg != ST_IDLE);
    assign thre        = (fifo.tf_count == FIFO_EMPTY);
    assign temt        = thre && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_peripheral_uart_tx_ctrl_wb.sv
// Bench for the UART transmit sequencer: a queue model of the TX FIFO, a
// per-tick scoreboard of expected line levels, a table of frame formats, and
// hand-written sequences for gaps, slow enable, break and mid-frame reset.
module tb_peripheral_uart_tx_ctrl_wb;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       enable = 1'b1;
    logic [7:0] lcr;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic       tx_busy;
    logic       thre;
    logic       temt;

    peripheral_uart_tx_ctrl_wb_if #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) fif ();

    peripheral_uart_tx_ctrl_wb #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .lcr       (lcr),
        .fifo      (fif),
        .stx_pad_o (stx_pad_o),
        .tstate    (tstate),
        .tx_busy   (tx_busy),
        .thre      (thre),
        .temt      (temt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pop_cnt = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         div4 = 1'b0;
    logic [7:0] fifo_q[$];
    bit         exp_q[$];

    typedef struct {
        logic [7:0] lcr;
        logic [7:0] data;
        int         nbits;
        bit         pe;
        bit         par;
        int         stop_n;
    } vec_t;

    vec_t vec[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fif.tf_count    = 5'(fifo_q.size());
        fif.tf_data_out = fifo_q[0];
    endtask

    // Expected line level for every counted enable tick of one frame.
    task automatic push_exp(input logic [7:0] data, input int nbits, input bit pe,
                            input bit par, input int stop_n);
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            repeat (16) exp_q.push_back(data[i]);
        end
        if (pe) begin
            repeat (16) exp_q.push_back(par);
        end
        repeat (stop_n) exp_q.push_back(1'b1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (tstate !== s && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tstate !== s) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=%0d required=%0d", name, tstate, s);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(tstate == 3'd0 && fifo_q.size() == 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!(tstate == 3'd0 && fifo_q.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=%0d required=0", name, tstate);
        end
    endtask

    // TX FIFO model: head entry and occupancy follow the queue.
    always @(posedge clk) begin
        if (fif.tf_pop) begin
            pop_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        fif.tf_count    <= 5'(fifo_q.size());
        fif.tf_data_out <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Baud enable: every clk, or every 4th clk when stretched.
    always @(posedge clk) begin
        cyc++;
        #1 enable = div4 ? ((cyc % 4) == 0) : 1'b1;
    end

    // Scoreboard: each counted enable tick of a frame pops one expected level.
    always @(negedge clk) begin
        if (mon_en && !wb_rst_i && enable && tstate >= 3'd2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL line_unexpected actual=%0b required=none state=%0d", stx_pad_o, tstate);
            end else begin
                check("line_level", 32'(stx_pad_o), 32'(exp_q.pop_front()));
            end
        end
        if (fif.tf_pop === 1'b1) begin
            check("pop_nonempty", 32'(fif.tf_count == 5'd0), 32'd0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        vec[0] = '{8'h03, 8'h55, 8, 1'b0, 1'b0, 16};
        vec[1] = '{8'h1B, 8'h07, 8, 1'b1, 1'b1, 16};
        vec[2] = '{8'h0B, 8'h07, 8, 1'b1, 1'b0, 16};
        vec[3] = '{8'h3B, 8'h07, 8, 1'b1, 1'b0, 16};
        vec[4] = '{8'h04, 8'hFF, 5, 1'b0, 1'b0, 24};
        vec[5] = '{8'h07, 8'hA5, 8, 1'b0, 1'b0, 32};
        vec[6] = '{8'h0A, 8'hFF, 7, 1'b1, 1'b0, 16};
        vec[7] = '{8'h2D, 8'h3C, 6, 1'b1, 1'b1, 32};
        vec[8] = '{8'h1C, 8'h13, 5, 1'b1, 1'b1, 24};

        // Reset state
        wb_rst_i        = 1'b1;
        lcr             = 8'h00;
        fif.tf_count    = 5'd0;
        fif.tf_data_out = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_stx", 32'(stx_pad_o), 32'd1);
        check("rst_pop", 32'(fif.tf_pop), 32'd0);
        check("rst_tstate", 32'(tstate), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_temt", 32'(temt), 32'd1);
        check("rst_thre", 32'(thre), 32'd1);
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_stx", 32'(stx_pad_o), 32'd1);

        // Frame formats from the table
        for (int i = 0; i < 9; i++) begin
            lcr = vec[i].lcr;
            p0  = pop_cnt;
            push_exp(vec[i].data, vec[i].nbits, vec[i].pe, vec[i].par, vec[i].stop_n);
            push_byte(vec[i].data);
            wait_done("frame");
            check("frame_drained", 32'(exp_q.size()), 32'd0);
            check("frame_pops", 32'(pop_cnt - p0), 32'd1);
            check("frame_temt", 32'(temt), 32'd1);
            $display("frame %0d lcr=%02h data=%02h pops=%0d", i, vec[i].lcr, vec[i].data, pop_cnt - p0);
        end

        // Three queued bytes: exactly 2 high clk between frames
        lcr = 8'h03;
        p0  = pop_cnt;
        push_exp(8'h55, 8, 1'b0, 1'b0, 16);
        push_exp(8'hA3, 8, 1'b0, 1'b0, 16);
        push_exp(8'h0F, 8, 1'b0, 1'b0, 16);
        push_byte(8'h55);
        push_byte(8'hA3);
        push_byte(8'h0F);
        for (int g = 0; g < 2; g++) begin
            wait_state(3'd5, "stop");
            n = 0;
            while (tstate == 3'd5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (tstate != 3'd2 && n < 50) begin
                check("gap_high", 32'(stx_pad_o), 32'd1);
                n++;
                @(negedge clk);
            end
            check("gap_len", 32'(n), 32'd2);
        end
        wait_done("burst");
        check("burst_pops", 32'(pop_cnt - p0), 32'd3);
        check("burst_drained", 32'(exp_q.size()), 32'd0);
        $display("burst frames=3 pops=%0d", pop_cnt - p0);

        // Enable every 4th clk: 64 clk per bit
        div4 = 1'b1;
        p0   = pop_cnt;
        push_exp(8'h55, 8, 1'b0, 1'b0, 16);
        push_byte(8'h55);
        wait_state(3'd3, "slow_data");
        n = 0;
        while (stx_pad_o == 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("slow_bit0_len", 32'(n), 32'd64);
        n = 0;
        while (stx_pad_o == 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("slow_bit1_len", 32'(n), 32'd64);
        wait_done("slow");
        div4 = 1'b0;
        check("slow_pops", 32'(pop_cnt - p0), 32'd1);
        check("slow_drained", 32'(exp_q.size()), 32'd0);
        $display("slow frame data=55 pops=%0d", pop_cnt - p0);

        // Break mid-frame: line held low while the FSM advances
        mon_en = 1'b0;
        lcr    = 8'h03;
        p0     = pop_cnt;
        push_byte(8'hFF);
        wait_state(3'd3, "brk_data");
        repeat (2) @(negedge clk);
        lcr = 8'h43;
        repeat (3) @(negedge clk);
        check("break_low", 32'(stx_pad_o), 32'd0);
        wait_state(3'd5, "brk_stop");
        check("break_stop_state", 32'(tstate), 32'd5);
        check("break_stop_low", 32'(stx_pad_o), 32'd0);
        lcr = 8'h03;
        @(negedge clk);
        check("break_release", 32'(stx_pad_o), 32'd1);
        wait_done("brk");
        check("break_pops", 32'(pop_cnt - p0), 32'd1);
        $display("break frame data=ff pops=%0d", pop_cnt - p0);

        // Reset during DATA: immediate idle, no further pop
        p0 = pop_cnt;
        push_byte(8'h00);
        wait_state(3'd3, "rst_data");
        repeat (5) @(negedge clk);
        check("pre_rst_stx", 32'(stx_pad_o), 32'd0);
        #1 wb_rst_i = 1'b1;
        #1;
        check("midrst_stx", 32'(stx_pad_o), 32'd1);
        check("midrst_tstate", 32'(tstate), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_pops", 32'(pop_cnt - p0), 32'd1);
        check("midrst_idle", 32'(tstate), 32'd0);
        check("midrst_line", 32'(stx_pad_o), 32'd1);
        $display("reset frame data=00 pops=%0d", pop_cnt - p0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
